// File: rtl/data_mem_if.sv
// Load/store request bus between the MEM-stage requester and the data memory responder.
// The requester holds MemRead/MemWrite until it sees ready; read_data/err are valid with ready.
interface data_mem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output MemRead, MemWrite, addr, write_data,
    input  read_data, ready, err, busy
  );

  modport slave (
    input  MemRead, MemWrite, addr, write_data,
    output read_data, ready, err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind an IDLE/WAIT/RESP handshake with programmable wait states.
// Bad requests (misaligned, out of range, read+write) complete with err and touch nothing.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  mem
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        rd_reg, wr_reg;
  logic        err_reg;
  logic [31:0] read_data_reg;

  logic [31:0] ram [DEPTH];

  logic          accept;
  logic          commit;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          c_rd, c_wr;
  logic          c_err;
  logic [AW-1:0] c_idx;

  assign accept = (state_reg == IDLE) && (mem.MemRead || mem.MemWrite);

  // With zero wait states the commit happens on the accept edge itself,
  // so the request has to come straight from the bus rather than the latches.
  assign c_addr  = accept ? mem.addr       : addr_reg;
  assign c_wdata = accept ? mem.write_data : wdata_reg;
  assign c_rd    = accept ? mem.MemRead    : rd_reg;
  assign c_wr    = accept ? mem.MemWrite   : wr_reg;
  assign c_idx   = c_addr[AW+1:2];
  assign c_err   = (c_addr[1:0] != 2'b00) || (|c_addr[31:AW+2]) || (c_rd && c_wr);
  assign commit  = (state_next == RESP) && (state_reg != RESP);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'(WAIT_STATES)) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      err_reg       <= 1'b0;
      read_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= mem.addr;
        wdata_reg <= mem.write_data;
        rd_reg    <= mem.MemRead;
        wr_reg    <= mem.MemWrite;
      end
      if (commit) begin
        err_reg <= c_err;
        if (c_rd && !c_err) begin
          read_data_reg <= ram[c_idx];
        end
      end
    end
  end

  // RAM contents survive reset; only the commit edge writes.
  always_ff @(posedge clk) begin
    if (commit && c_wr && !c_err) begin
      ram[c_idx] <= c_wdata;
    end
  end

  assign mem.read_data = read_data_reg;
  assign mem.ready     = (state_reg == RESP);
  assign mem.err       = (state_reg == RESP) && err_reg;
  assign mem.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: one instance with 2 wait states, one with none,
// both checked against a plain array model of the RAM and the response timing rules.
module tb_data_mem_responder;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_if bus0 ();
  data_mem_if bus1 ();

  logic        rd_q   [2];
  logic        wr_q   [2];
  logic [31:0] addr_q [2];
  logic [31:0] wd_q   [2];
  logic [31:0] rdata_w[2];
  logic        ready_w[2];
  logic        err_w  [2];
  logic        busy_w [2];

  assign bus0.MemRead    = rd_q[0];
  assign bus0.MemWrite   = wr_q[0];
  assign bus0.addr       = addr_q[0];
  assign bus0.write_data = wd_q[0];
  assign bus1.MemRead    = rd_q[1];
  assign bus1.MemWrite   = wr_q[1];
  assign bus1.addr       = addr_q[1];
  assign bus1.write_data = wd_q[1];
  assign rdata_w[0] = bus0.read_data;
  assign ready_w[0] = bus0.ready;
  assign err_w[0]   = bus0.err;
  assign busy_w[0]  = bus0.busy;
  assign rdata_w[1] = bus1.read_data;
  assign ready_w[1] = bus1.ready;
  assign err_w[1]   = bus1.err;
  assign busy_w[1]  = bus1.busy;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem(bus0.slave)
  );
  data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem(bus1.slave)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          ws_tab[2];
  logic [31:0] m_ram  [2][DEPTH];
  logic [31:0] m_rdata[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input int sel);
    int n = 0;
    @(negedge clk);
    while (busy_w[sel] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(busy_w[sel]), 32'd0);
  endtask

  // One request; the reference says: ready WAIT_STATES+1 edges after the accept edge,
  // errors leave RAM and read_data alone, good writes update RAM, good reads return RAM.
  task automatic txn(input int sel, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d);
    int lat = 0;
    bit got = 0;
    bit exp_err;
    int idx;
    wait_idle(sel);
    rd_q[sel] = rd; wr_q[sel] = wr; addr_q[sel] = a; wd_q[sel] = d;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ready_w[sel] === 1'b1) got = 1;
    end
    rd_q[sel] = 1'b0; wr_q[sel] = 1'b0;
    exp_err = (a % 4 != 0) || (a >= 32'(4 * DEPTH)) || (rd && wr);
    idx     = int'((a / 4) % DEPTH);
    if (!exp_err) begin
      if (wr) m_ram[sel][idx] = d;
      else    m_rdata[sel] = m_ram[sel][idx];
    end
    check("latency", 32'(lat), 32'(ws_tab[sel] + 1));
    check("err", 32'(err_w[sel]), 32'(exp_err));
    check("read_data", rdata_w[sel], m_rdata[sel]);
    $display("txn dut%0d rd=%0b wr=%0b addr=0x%08h wdata=0x%08h lat=%0d err=%0b rdata=0x%08h",
             sel, rd, wr, a, d, lat, err_w[sel], rdata_w[sel]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          k, r, sel;
    ws_tab[0] = 2;
    ws_tab[1] = 0;
    for (int s = 0; s < 2; s++) begin
      rd_q[s] = 1'b0; wr_q[s] = 1'b0; addr_q[s] = 32'd0; wd_q[s] = 32'd0;
      m_rdata[s] = 32'd0;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check("rst_ready", 32'(ready_w[s]), 32'd0);
        check("rst_busy", 32'(busy_w[s]), 32'd0);
        check("rst_err", 32'(err_w[s]), 32'd0);
        check("rst_rdata", rdata_w[s], 32'd0);
      end
    end

    // Fill the first 16 words of both memories so every later read has a known value.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        txn(s, 1'b0, 1'b1, 32'(w * 4), $urandom);

    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("rd_deadbeef", rdata_w[0], 32'hDEADBEEF);

    txn(1, 1'b0, 1'b1, 32'h0, 32'h1);
    txn(1, 1'b0, 1'b1, 32'h4, 32'h2);
    txn(1, 1'b1, 1'b0, 32'h0, 32'h0);
    check("rd_one", rdata_w[1], 32'h1);
    txn(1, 1'b1, 1'b0, 32'h4, 32'h0);
    check("rd_two", rdata_w[1], 32'h2);

    for (int s = 0; s < 2; s++) begin
      txn(s, 1'b0, 1'b1, 32'h8, 32'hA5A5_0008);
      txn(s, 1'b1, 1'b0, 32'h6, 32'h0);
      txn(s, 1'b0, 1'b1, 32'(4 * DEPTH), 32'h1111_2222);
      txn(s, 1'b1, 1'b1, 32'h8, 32'h3333_4444);
      txn(s, 1'b1, 1'b0, 32'h8, 32'h0);
      check("ram8_kept", rdata_w[s], 32'hA5A5_0008);
    end

    // Abort a write during WAIT: the old word at 0x20 must survive.
    txn(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
    wait_idle(0);
    wr_q[0] = 1'b1; addr_q[0] = 32'h20; wd_q[0] = 32'h55;
    @(posedge clk); #1;
    check("wait_busy", 32'(busy_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    wr_q[0] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_rdata[s] = 32'd0;
      check("arst_busy", 32'(busy_w[s]), 32'd0);
      check("arst_ready", 32'(ready_w[s]), 32'd0);
      check("arst_rdata", rdata_w[s], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0);
    check("abort_kept", rdata_w[0], 32'h1234_5678);

    // Hold MemRead across ready: IDLE shows up for exactly one cycle between responses.
    for (int s = 0; s < 2; s++) begin
      wait_idle(s);
      rd_q[s] = 1'b1; addr_q[s] = 32'h10;
      m_rdata[s] = m_ram[s][4];
      for (int i = 0; i < 2 * (ws_tab[s] + 2) - 1; i++) begin
        int ph;
        @(posedge clk); #1;
        ph = i % (ws_tab[s] + 2);
        check("hold_busy", 32'(busy_w[s]), 32'(ph != ws_tab[s] + 1));
        check("hold_ready", 32'(ready_w[s]), 32'(ph == ws_tab[s]));
        if (ph == ws_tab[s]) check("hold_rdata", rdata_w[s], m_rdata[s]);
      end
      rd_q[s] = 1'b0;
      $display("txn dut%0d held read addr=0x00000010 two responses rdata=0x%08h", s, rdata_w[s]);
    end

    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      a   = 32'($urandom_range(0, 15) * 4);
      if (r == 0)      a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000) * 4);
      k = int'($urandom_range(0, 5));
      txn(sel, (k == 0) || (k >= 3), (k <= 2), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
